mem_req_arbiter: RTL and testbench
==================================

Name: mem_req_arbiter

Overview:
- Two-port arbiter that shares the single cache/memory system between the instruction-fetch requester (port I) and the data-memory requester (port D).
- Sits between the pipeline fetch/memory stages and the cache memory system (set-associative cache plus four-bank main memory with its controller FSM).
- Latches the winning request, issues it downstream as a one-cycle Rd/Wr strobe, and holds address/data stable until downstream Done.
- Routes the response back to the granted port; the losing port stalls.

Parameters:
- AW, 16, address width
- DW, 16, data width
- TIMEOUT, 63, WAIT-state cycle limit; used only when MEM_ARB_TIMEOUT_EN is defined

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset (rst==0 resets on rising clk edge)
- i_rd, i_wr  in  1 each  fetch read/write request; level, held until i_done
- i_addr  in  AW  fetch address
- i_wdata  in  DW  fetch write data
- i_rdata  out  DW  fetch read data
- i_done, i_hit  out  1 each  fetch completion / cache hit
- i_stall  out  1  fetch must hold
- d_rd, d_wr, d_addr, d_wdata, d_rdata, d_done, d_hit, d_stall  same as i_* for the data port
- m_rd, m_wr  out  1 each  downstream request strobe
- m_addr  out  AW  downstream address
- m_wdata  out  DW  downstream write data
- m_rdata  in  DW  downstream read data
- m_done, m_hit, m_stall, m_err  in  1 each  downstream status
- err  out  1  arbiter error flag

Behaviour:
- States:
  - IDLE: no request outstanding.
  - ISSUE: m_rd/m_wr asserted for exactly one cycle.
  - WAIT: waiting for m_done.
- Legal request per port: rd XOR wr. rd&wr on a port is illegal: that port is never granted, err=1 while the condition persists.
- IDLE:
  - If no legal request, stay.
  - If one port has a legal request, grant it.
  - If both do, grant the port != last_grant (round-robin).
  - On grant: latch grant, op, addr, wdata into hold registers; update last_grant; go to ISSUE.
- ISSUE:
  - m_rd = op_is_rd, m_wr = ~op_is_rd; go to WAIT unconditionally.
  - m_done in ISSUE is ignored.
- WAIT:
  - m_rd = m_wr = 0.
  - m_addr/m_wdata stay driven from hold registers.
  - On m_done: for the granted port, x_done=1, x_rdata=m_rdata, x_hit=m_hit (combinational, same cycle); go to IDLE.
- m_addr/m_wdata come from hold registers in ISSUE and WAIT, and are 0 in IDLE.
- Latency: request seen in IDLE cycle N, strobe in N+1, earliest x_done in N+2. Back-to-back grants are separated by one IDLE cycle.
- x_stall = (x_rd|x_wr) & ~x_done.
- x_rdata/x_hit are 0 whenever x_done=0.
- Requester inputs are sampled only in IDLE; changes after grant are ignored.
- err = illegal_I | illegal_D | m_err | timeout_pulse. m_err does not abort WAIT.
- Reset, including mid-transaction: state=IDLE, last_grant=D (so I wins the first tie), hold registers=0, all outputs 0. An interrupted requester must re-present its request.

Optional Feature:
- Macro MEM_ARB_TIMEOUT_EN.
- When defined:
  - An 8-bit WAIT counter clears on entry to WAIT.
  - If it reaches TIMEOUT without m_done, err pulses for 1 cycle.
  - The granted port gets x_done=1 with x_rdata=0, x_hit=0, and the FSM returns to IDLE.
- When undefined: no counter; WAIT persists until m_done; timeout_pulse is constant 0.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding constants ST_IDLE=2'b00, ST_ISSUE=2'b01, ST_WAIT=2'b10
  - port ids PORT_I=1'b0, PORT_D=1'b1
  - TIMEOUT counter width
- One sub-module: arb_rr2, a combinational 2-way round-robin picker. Inputs: req[1:0], last. Outputs: gnt_valid, gnt_id.
- State and hold registers use the existing dff/dff_en cells.

Test Plan:
- Single fetch read hit: i_rd=1, i_addr=0x0010 in IDLE; m_done=1, m_hit=1, m_rdata=0xBEEF in cycle N+2 -> m_rd high only in N+1, m_addr=0x0010, i_done=1, i_rdata=0xBEEF, i_hit=1 in N+2, d_* all 0.
- Simultaneous requests after reset: i_rd (0x0020) and d_wr (0x0400, 0x1234) in the same cycle -> I granted first. D is granted in the IDLE cycle after i_done, with m_wr=1, m_wdata=0x1234, and d_stall=1 throughout.
- Round-robin fairness: both ports request continuously for 6 transactions, each m_done 4 cycles after strobe -> grant order I,D,I,D,I,D.
- Miss with long latency: d_rd, m_done withheld for 20 cycles -> m_addr stable, m_rd one cycle only, d_stall=1 until d_done, i_wr arriving meanwhile is not granted until D completes.
- Illegal request and reset: d_rd=d_wr=1 -> err=1, D never granted, I still served. Then assert rst=0 during WAIT -> next cycle state IDLE, all outputs 0, no done pulse.
- MEM_ARB_TIMEOUT_EN with TIMEOUT=63, m_done never asserted -> err pulses 1 cycle, i_done=1, i_rdata=0, FSM back in IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared constants for the I/D memory request arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10
  } arb_state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Width of the WAIT-state watchdog counter (optional timeout build only).
  localparam int TO_CNT_W = 8;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: on a tie the port that did not win last time wins.
// Latency: combinational.
// Backpressure: none; caller decides when the pick is consumed.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_id
);

  // single requester wins outright; a tie goes to the port opposite last
  always_comb begin
    gnt_valid = |req;
    gnt_id    = PORT_I;
    if (req[PORT_I] && req[PORT_D]) gnt_id = ~last;
    else if (req[PORT_D])           gnt_id = PORT_D;
  end

endmodule

// File: rtl/dff.sv
// Plain register cell with synchronous active-low clear.
// Latency: 1 cycle.
// Backpressure: none; captures d every cycle.
module dff #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // capture every cycle, clear to RST_VAL while rst is low
  always_ff @(posedge clk) begin
    if (!rst) q <= RST_VAL;
    else      q <= d;
  end

endmodule

// File: rtl/dff_en.sv
// Load-enable register cell with synchronous active-low clear.
// Latency: 1 cycle after en.
// Backpressure: none; holds value while en is low.
module dff_en #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // load on en, clear to RST_VAL while rst is low
  always_ff @(posedge clk) begin
    if (!rst)    q <= RST_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one cache/memory port between fetch (I) and data (D); optional WAIT watchdog under MEM_ARB_TIMEOUT_EN.
// Latency: request in IDLE cycle N -> m_rd/m_wr strobe in N+1 -> earliest x_done in N+2; one IDLE cycle between grants.
// Backpressure: loser (and winner until x_done) sees x_stall; WAIT holds until m_done (or watchdog expiry).
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 63
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_rd,
  input  logic          i_wr,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] i_rdata,
  output logic          i_done,
  output logic          i_hit,
  output logic          i_stall,
  input  logic          d_rd,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          d_hit,
  output logic          d_stall,
  output logic          m_rd,
  output logic          m_wr,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_done,
  input  logic          m_hit,
  input  logic          m_stall,
  input  logic          m_err,
  output logic          err
);

  localparam logic [TO_CNT_W-1:0] TO_LIMIT = TO_CNT_W'(TIMEOUT);

  arb_state_t    state_q, state_d;
  logic [1:0]    state_raw;
  logic          legal_i, legal_d, illegal_i, illegal_d;
  logic          gnt_valid, gnt_id, grant;
  logic          last_q, gnt_q, op_rd_q;
  logic [AW-1:0] addr_q, sel_addr;
  logic [DW-1:0] wdata_q, sel_wdata;
  logic          sel_rd;
  logic          in_wait, busy, done_any, data_ok;
  logic          timeout_pulse;
  logic          unused_sink;

  // rd and wr together is a malformed request: never granted, flagged on err
  assign illegal_i = i_rd & i_wr;
  assign illegal_d = d_rd & d_wr;
  assign legal_i   = i_rd ^ i_wr;
  assign legal_d   = d_rd ^ d_wr;

  arb_rr2 u_pick (
    .req       ({legal_d, legal_i}),
    .last      (last_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // requester inputs only matter in IDLE; after this they are ignored
  assign grant     = (state_q == ST_IDLE) & gnt_valid;
  assign sel_rd    = (gnt_id == PORT_D) ? d_rd    : i_rd;
  assign sel_addr  = (gnt_id == PORT_D) ? d_addr  : i_addr;
  assign sel_wdata = (gnt_id == PORT_D) ? d_wdata : i_wdata;

  dff #(.W(2), .RST_VAL(ST_IDLE)) u_state (
    .clk(clk), .rst(rst), .d(state_d), .q(state_raw)
  );
  assign state_q = arb_state_t'(state_raw);

  // last_grant resets to D so fetch wins the first tie
  dff_en #(.W(1), .RST_VAL(PORT_D)) u_last (
    .clk(clk), .rst(rst), .en(grant), .d(gnt_id), .q(last_q)
  );
  dff_en #(.W(1)) u_gnt (
    .clk(clk), .rst(rst), .en(grant), .d(gnt_id), .q(gnt_q)
  );
  dff_en #(.W(1)) u_op (
    .clk(clk), .rst(rst), .en(grant), .d(sel_rd), .q(op_rd_q)
  );
  dff_en #(.W(AW)) u_addr (
    .clk(clk), .rst(rst), .en(grant), .d(sel_addr), .q(addr_q)
  );
  dff_en #(.W(DW)) u_wdata (
    .clk(clk), .rst(rst), .en(grant), .d(sel_wdata), .q(wdata_q)
  );

  // next-state and one-cycle downstream strobe; m_done outside WAIT is ignored
  always_comb begin
    state_d = state_q;
    m_rd    = 1'b0;
    m_wr    = 1'b0;
    case (state_q)
      ST_IDLE:  if (gnt_valid) state_d = ST_ISSUE;
      ST_ISSUE: begin
        m_rd    = op_rd_q;
        m_wr    = ~op_rd_q;
        state_d = ST_WAIT;
      end
      ST_WAIT:  if (m_done || timeout_pulse) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign in_wait = (state_q == ST_WAIT);
  assign busy    = (state_q == ST_ISSUE) | in_wait;
  assign m_addr  = busy ? addr_q  : '0;
  assign m_wdata = busy ? wdata_q : '0;

  // response data is forwarded only on a real m_done; a watchdog completion returns zeros
  assign done_any = in_wait & (m_done | timeout_pulse);
  assign data_ok  = in_wait & m_done;

  assign i_done  = done_any & (gnt_q == PORT_I);
  assign d_done  = done_any & (gnt_q == PORT_D);
  assign i_rdata = (data_ok && gnt_q == PORT_I) ? m_rdata : '0;
  assign d_rdata = (data_ok && gnt_q == PORT_D) ? m_rdata : '0;
  assign i_hit   = data_ok & (gnt_q == PORT_I) & m_hit;
  assign d_hit   = data_ok & (gnt_q == PORT_D) & m_hit;
  assign i_stall = (i_rd | i_wr) & ~i_done;
  assign d_stall = (d_rd | d_wr) & ~d_done;

  // m_err is reported but does not abort an outstanding WAIT
  assign err = illegal_i | illegal_d | m_err | timeout_pulse;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [TO_CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  // counter is zero on the first WAIT cycle and counts up while waiting
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == ST_ISSUE) wait_cnt_d = '0;
    else if (in_wait)        wait_cnt_d = wait_cnt_q + TO_CNT_W'(1);
  end

  dff #(.W(TO_CNT_W)) u_wait_cnt (
    .clk(clk), .rst(rst), .d(wait_cnt_d), .q(wait_cnt_q)
  );

  assign timeout_pulse = in_wait & ~m_done & (wait_cnt_q == TO_LIMIT);
  assign unused_sink   = m_stall;
`else
  assign timeout_pulse = 1'b0;
  assign unused_sink   = ^{m_stall, TO_LIMIT};
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter: transaction-level model predicts grants, strobes and completions.
// Latency: n/a.
// Backpressure: requesters hold their request until done, as a real pipeline stage would.
module tb_mem_req_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 63;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_rd = 1'b0, i_wr = 1'b0, d_rd = 1'b0, d_wr = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] i_wdata = '0, d_wdata = '0;
  logic [DW-1:0] i_rdata, d_rdata, m_wdata;
  logic [AW-1:0] m_addr;
  logic          i_done, i_hit, i_stall, d_done, d_hit, d_stall, m_rd, m_wr, err;
  logic [DW-1:0] m_rdata = '0;
  logic          m_done = 1'b0, m_hit = 1'b0, m_stall = 1'b0, m_err = 1'b0;

  always #5 clk = ~clk;

  mem_req_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_rd(i_rd), .i_wr(i_wr), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_done(i_done), .i_hit(i_hit), .i_stall(i_stall),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_hit(d_hit), .d_stall(d_stall),
    .m_rd(m_rd), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_done(m_done), .m_hit(m_hit), .m_stall(m_stall),
    .m_err(m_err), .err(err)
  );

  typedef struct { int cyc; logic rd; logic [AW-1:0] addr; logic [DW-1:0] wdata; } strobe_t;
  typedef struct { int cyc; int port; logic [DW-1:0] rdata; logic hit; } done_t;

  strobe_t sq[$];
  done_t   dq[$];
  int      grant_log[$];

  int n_chk = 0, n_fail = 0, cyc = 0;
  bit chk_en = 0;

  // requester state, index 0 = fetch, 1 = data
  bit            p_on[2], p_rd[2], p_wr[2];
  logic [AW-1:0] p_addr[2];
  logic [DW-1:0] p_wdata[2];
  int            p_life[2];

  // arbiter reference: one transaction at a time, round robin on ties
  bit            busy = 0, g_rd = 0, g_to = 0;
  int            g_port = 0, strobe_cyc = 0, done_cyc = 0, last = 1, idle_from = 0;
  logic [AW-1:0] g_addr = '0;
  logic [DW-1:0] g_wdata = '0, r_data = '0;
  logic          r_hit = 0;

  // knobs for directed tests
  bit            rand_mode = 0, rst_req = 1, plan_fixed = 0, plan_hit = 0, plan_to = 0;
  int            plan_lat = 0, refill_left = 0;
  logic [DW-1:0] plan_data = '0;

  // per-cycle expectations consumed by the monitor
  bit            e_done[2], e_err = 0, e_to = 0, e_busy = 0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0;

  function automatic void chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endfunction

  function automatic void set_req(input int p, input bit rd, input bit wr,
                                  input logic [AW-1:0] a, input logic [DW-1:0] w, input int life);
    p_on[p] = 1; p_rd[p] = rd; p_wr[p] = wr; p_addr[p] = a; p_wdata[p] = w; p_life[p] = life;
  endfunction

  function automatic void new_req(input int p, input bit bad);
    p_on[p] = 1; p_addr[p] = AW'($urandom); p_wdata[p] = DW'($urandom);
    if (bad) begin p_rd[p] = 1; p_wr[p] = 1; p_life[p] = $urandom_range(0, 3); end
    else begin p_rd[p] = 1'($urandom); p_wr[p] = !p_rd[p]; end
  endfunction

  task automatic run_cycle();
    bit legal[2];
    int pick, lat;
    @(posedge clk); #1;
    cyc++;
    m_done = 0; m_rdata = DW'($urandom); m_hit = 1'($urandom); m_err = 0;
    if (busy && done_cyc == cyc - 1) begin busy = 0; p_on[g_port] = 0; end
    for (int p = 0; p < 2; p++)
      if (p_on[p] && p_rd[p] && p_wr[p]) begin
        p_life[p]--;
        if (p_life[p] < 0) p_on[p] = 0;
      end
    for (int p = 0; p < 2; p++) begin
      if (rst_req) p_on[p] = 0;
      else if (!p_on[p]) begin
        if (refill_left > 0) begin new_req(p, 0); refill_left--; end
        else if (rand_mode && $urandom_range(0, 2) == 0) new_req(p, $urandom_range(0, 9) == 0);
      end
    end
    if (rand_mode && $urandom_range(0, 15) == 0) m_err = 1;
    rst = !rst_req;
    i_rd = p_on[0] & p_rd[0]; i_wr = p_on[0] & p_wr[0]; i_addr = p_addr[0]; i_wdata = p_wdata[0];
    d_rd = p_on[1] & p_rd[1]; d_wr = p_on[1] & p_wr[1]; d_addr = p_addr[1]; d_wdata = p_wdata[1];
    // after grant the requester's address/data lines may wander; the arbiter must not care
    if (busy) begin
      if (g_port == 0) begin i_addr = AW'($urandom); i_wdata = DW'($urandom); end
      else begin d_addr = AW'($urandom); d_wdata = DW'($urandom); end
    end
    e_done[0] = 0; e_done[1] = 0; e_to = 0;
    if (busy) begin
      if (cyc == done_cyc) begin
        e_done[g_port] = 1;
        if (g_to) begin e_to = 1; dq.push_back('{cyc, g_port, '0, 1'b0}); end
        else begin
          m_done = 1; m_rdata = r_data; m_hit = r_hit;
          dq.push_back('{cyc, g_port, r_data, r_hit});
        end
      end
    end else if (!rst_req && cyc >= idle_from) begin
      for (int p = 0; p < 2; p++) legal[p] = p_on[p] && (p_rd[p] != p_wr[p]);
      if (legal[0] || legal[1]) begin
        if (legal[0] && legal[1]) pick = 1 - last;
        else pick = legal[0] ? 0 : 1;
        last = pick; busy = 1; g_port = pick;
        g_rd = p_rd[pick]; g_addr = p_addr[pick]; g_wdata = p_wdata[pick];
        strobe_cyc = cyc + 1;
        sq.push_back('{strobe_cyc, g_rd, g_addr, g_wdata});
        grant_log.push_back(pick);
        g_to   = plan_to;
        lat    = (plan_lat > 0) ? plan_lat : $urandom_range(1, 8);
        r_data = plan_fixed ? plan_data : DW'($urandom);
        r_hit  = plan_fixed ? plan_hit  : 1'($urandom);
        done_cyc  = g_to ? strobe_cyc + TO + 1 : strobe_cyc + lat;
        idle_from = done_cyc + 1;
      end
    end
    e_busy  = busy && cyc >= strobe_cyc;
    e_addr  = e_busy ? g_addr  : '0;
    e_wdata = e_busy ? g_wdata : '0;
    e_err   = (i_rd & i_wr) | (d_rd & d_wr) | m_err | e_to;
    if (rst_req) begin busy = 0; last = 1; idle_from = cyc + 1; end
  endtask

  task automatic drain();
    int n = 0;
    while ((busy || p_on[0] || p_on[1] || refill_left > 0) && n < 400) begin run_cycle(); n++; end
    run_cycle(); run_cycle();
  endtask

  task automatic pulse_reset();
    rst_req = 1; run_cycle(); rst_req = 0;
  endtask

  task automatic chk_quiet(input string tag);
    chk_eq({tag, "_m_rd"}, m_rd, 0);       chk_eq({tag, "_m_wr"}, m_wr, 0);
    chk_eq({tag, "_m_addr"}, m_addr, 0);   chk_eq({tag, "_m_wdata"}, m_wdata, 0);
    chk_eq({tag, "_i_done"}, i_done, 0);   chk_eq({tag, "_d_done"}, d_done, 0);
    chk_eq({tag, "_i_rdata"}, i_rdata, 0); chk_eq({tag, "_d_rdata"}, d_rdata, 0);
    chk_eq({tag, "_i_hit"}, i_hit, 0);     chk_eq({tag, "_d_hit"}, d_hit, 0);
    chk_eq({tag, "_i_stall"}, i_stall, 0); chk_eq({tag, "_d_stall"}, d_stall, 0);
    chk_eq({tag, "_err"}, err, 0);
  endtask

  task automatic chk_order(input string tag, input int exp[$]);
    chk_eq({tag, "_count"}, grant_log.size(), exp.size());
    for (int k = 0; k < exp.size() && k < grant_log.size(); k++)
      chk_eq({tag, "_port"}, grant_log[k], exp[k]);
  endtask

  strobe_t mon_s;
  done_t   mon_d;

  // monitor: pops expectations whenever the DUT strobes or completes
  always @(negedge clk) begin
    if (chk_en) begin
      if (m_rd || m_wr) begin
        if (sq.size() == 0) chk_eq("strobe_unexpected", {m_rd, m_wr}, 0);
        else begin
          mon_s = sq.pop_front();
          chk_eq("strobe_cycle", cyc, mon_s.cyc);
          chk_eq("strobe_rd", m_rd, mon_s.rd);
          chk_eq("strobe_wr", m_wr, !mon_s.rd);
          chk_eq("strobe_addr", m_addr, mon_s.addr);
          chk_eq("strobe_wdata", m_wdata, mon_s.wdata);
        end
      end else if (sq.size() > 0 && sq[0].cyc <= cyc) begin
        chk_eq("strobe_missing", m_rd | m_wr, 1);
        void'(sq.pop_front());
      end
      if (i_done || d_done) begin
        if (dq.size() == 0) chk_eq("done_unexpected", {i_done, d_done}, 0);
        else begin
          mon_d = dq.pop_front();
          chk_eq("done_cycle", cyc, mon_d.cyc);
          chk_eq("done_port", {d_done, i_done}, (mon_d.port == 0) ? 2'b01 : 2'b10);
          chk_eq("done_rdata", (mon_d.port == 0) ? i_rdata : d_rdata, mon_d.rdata);
          chk_eq("done_hit", (mon_d.port == 0) ? i_hit : d_hit, mon_d.hit);
        end
      end else if (dq.size() > 0 && dq[0].cyc <= cyc) begin
        chk_eq("done_missing", i_done | d_done, 1);
        void'(dq.pop_front());
      end
      if (!i_done) chk_eq("i_resp_gated", {i_hit, i_rdata}, 0);
      if (!d_done) chk_eq("d_resp_gated", {d_hit, d_rdata}, 0);
      chk_eq("m_addr", m_addr, e_addr);
      chk_eq("m_wdata", m_wdata, e_wdata);
      chk_eq("i_stall", i_stall, (i_rd | i_wr) & !e_done[0]);
      chk_eq("d_stall", d_stall, (d_rd | d_wr) & !e_done[1]);
      chk_eq("err", err, e_err);
    end
  end

  initial begin
    for (int p = 0; p < 2; p++) begin
      p_on[p] = 0; p_rd[p] = 0; p_wr[p] = 0; p_addr[p] = '0; p_wdata[p] = '0; p_life[p] = 0;
      e_done[p] = 0;
    end
    // reset: the second reset cycle already shows the cleared state
    rst_req = 1; run_cycle(); chk_en = 1; run_cycle();
    @(negedge clk); chk_quiet("reset");
    rst_req = 0;

    // single fetch read hit, done one cycle after the strobe
    plan_fixed = 1; plan_lat = 1; plan_data = 16'hBEEF; plan_hit = 1;
    set_req(0, 1, 0, 16'h0010, 16'h0000, 0);
    drain();

    // simultaneous requests straight after reset: fetch wins the tie
    pulse_reset();
    grant_log.delete();
    plan_fixed = 0; plan_lat = 3;
    set_req(0, 1, 0, 16'h0020, 16'h0000, 0);
    set_req(1, 0, 1, 16'h0400, 16'h1234, 0);
    drain();
    chk_order("tie_after_reset", '{0, 1});

    // continuous requests on both ports alternate
    grant_log.delete();
    plan_lat = 4;
    set_req(0, 1, 0, 16'h1000, 16'h0001, 0);
    set_req(1, 0, 1, 16'h2000, 16'h0002, 0);
    refill_left = 4;
    drain();
    chk_order("round_robin", '{0, 1, 0, 1, 0, 1});

    // long miss on D; fetch write arriving meanwhile waits its turn
    grant_log.delete();
    plan_lat = 20;
    set_req(1, 1, 0, 16'h3456, 16'h0000, 0);
    run_cycle(); run_cycle(); run_cycle();
    plan_lat = 2;
    set_req(0, 0, 1, 16'h0ABC, 16'h5A5A, 0);
    drain();
    chk_order("long_miss", '{1, 0});

    // malformed D request is never granted while fetch is served
    grant_log.delete();
    plan_lat = 3;
    set_req(1, 1, 1, 16'h7777, 16'h7777, 12);
    set_req(0, 1, 0, 16'h0042, 16'h0000, 0);
    drain();
    chk_order("illegal_d", '{0});

    // reset in the middle of WAIT: no completion ever appears
    plan_lat = 10;
    set_req(0, 1, 0, 16'h0099, 16'h0000, 0);
    run_cycle(); run_cycle(); run_cycle(); run_cycle();
    pulse_reset();
    run_cycle();
    @(negedge clk); chk_quiet("mid_reset");
    repeat (12) run_cycle();

`ifdef MEM_ARB_TIMEOUT_EN
    // downstream never answers: watchdog completes with zero data and an err pulse
    plan_to = 1;
    set_req(0, 1, 0, 16'h0055, 16'h0000, 0);
    drain();
    plan_to = 0;
`endif

    // randomized traffic, latencies, malformed requests and m_err
    plan_lat = 0; plan_fixed = 0; rand_mode = 1;
    repeat (3000) run_cycle();
    rand_mode = 0;
    drain();

    @(negedge clk);
    chk_eq("strobes_outstanding", sq.size(), 0);
    chk_eq("dones_outstanding", dq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
